// File: rtl/pc_seq_ctrl.sv
// OTTER program-counter sequencer: owns the PC, runs the imem fetch handshake and picks the next PC.
// Optional performance counters are compiled in when PC_SEQ_PERF_EN is defined.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          OP_W      = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            next_valid,
    input  logic [OP_W-1:0] op,
    input  logic            br_taken,
    input  logic [31:0]     branch_adr,
    input  logic [31:0]     jal_adr,
    input  logic [31:0]     jalr_adr,
    input  logic [31:0]     mtvec,
    input  logic [31:0]     mepc,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ack,
    output logic [31:0]     pc,
    output logic            pc_valid,
    output logic            misalign_trap,
    output logic [31:0]     bad_target
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]     instr_cnt,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     fetch_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        ISSUE    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_target_q, bad_target_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        check_align;
    logic        not_seq;
    logic        misaligned;
    logic        accept;

    assign pc_plus4 = pc_q + 32'd4;
    assign accept   = (state_q == ISSUE) && next_valid;

    // Target mux; only branch-taken, jal and jalr targets are subject to the alignment check.
    always_comb begin
        target      = pc_plus4;
        check_align = 1'b0;
        not_seq     = 1'b0;
        case (op)
            OP_W'(1): begin
                if (br_taken) begin
                    target      = branch_adr;
                    check_align = 1'b1;
                    not_seq     = 1'b1;
                end
            end
            OP_W'(2): begin
                target      = jal_adr;
                check_align = 1'b1;
                not_seq     = 1'b1;
            end
            OP_W'(3): begin
                target      = {jalr_adr[31:1], 1'b0};
                check_align = 1'b1;
                not_seq     = 1'b1;
            end
            OP_W'(4): begin
                target  = mtvec;
                not_seq = 1'b1;
            end
            OP_W'(5): begin
                target  = mepc;
                not_seq = 1'b1;
            end
            default: begin
                target = pc_plus4;
            end
        endcase
    end

    assign misaligned = check_align && (target[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        bad_target_d = bad_target_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (next_valid) begin
                    if (misaligned) begin
                        pc_d         = mtvec;
                        bad_target_d = target;
                        state_d      = REDIRECT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end
            end
            REDIRECT: begin
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= FETCH;
            pc_q         <= RESET_VEC;
            bad_target_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            bad_target_q <= bad_target_d;
        end
    end

    // The reset state is FETCH, so the request is masked by RST to drop it immediately.
    assign imem_req      = (state_q == FETCH) && !RST;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign pc_valid      = (state_q == ISSUE);
    assign misalign_trap = (state_q == REDIRECT);
    assign bad_target    = bad_target_q;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] fetch_stall_cnt_q, fetch_stall_cnt_d;

    always_comb begin
        instr_cnt_d       = instr_cnt_q;
        redirect_cnt_d    = redirect_cnt_q;
        fetch_stall_cnt_d = fetch_stall_cnt_q;
        if (accept) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
            if (not_seq) begin
                redirect_cnt_d = redirect_cnt_q + 32'd1;
            end
        end
        if ((state_q == FETCH) && !imem_ack) begin
            fetch_stall_cnt_d = fetch_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_cnt_q       <= 32'd0;
            redirect_cnt_q    <= 32'd0;
            fetch_stall_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q       <= instr_cnt_d;
            redirect_cnt_q    <= redirect_cnt_d;
            fetch_stall_cnt_q <= fetch_stall_cnt_d;
        end
    end

    assign instr_cnt       = instr_cnt_q;
    assign redirect_cnt    = redirect_cnt_q;
    assign fetch_stall_cnt = fetch_stall_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = accept ^ not_seq;
`endif

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Program-counter sequencer for the OTTER core.
- Owns the PC register and runs the fetch handshake with instruction memory.
- After each instruction, selects the next PC from the branch-address generator outputs (BRANCH, JAL, JALR), PC+4, or the trap/return vectors.
- Detects misaligned control-flow targets and redirects them to the trap vector.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- OP_W, 3, width of the next-PC operation code.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- next_valid  in  1  execute stage presents a next-PC decision this cycle.
- op  in  OP_W  next-PC source: 0 seq, 1 branch, 2 jal, 3 jalr, 4 trap, 5 mret; 6 and 7 behave as seq.
- br_taken  in  1  branch condition result; used only when op=1.
- branch_adr  in  32  B-type target.
- jal_adr  in  32  J-type target.
- jalr_adr  in  32  I-type + rs1 target.
- mtvec  in  32  trap vector.
- mepc  in  32  return address for mret.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  fetch completed this cycle.
- pc  out  32  current PC.
- pc_valid  out  1  fetched instruction at pc is available to decode/execute.
- misalign_trap  out  1  one-cycle pulse: misaligned target detected.
- bad_target  out  32  offending target captured on misalign.

Behaviour:
- Reset (asynchronous, RST=1):
  - pc=RESET_VEC, state=FETCH.
  - imem_req=0, pc_valid=0, misalign_trap=0, bad_target=0.
  - Outputs take these values immediately, not at the next edge.
  - Reset asserted mid-fetch drops imem_req without waiting for imem_ack.
- First cycle after RST deasserts: FETCH, imem_req=1.
- States: FETCH, ISSUE, REDIRECT.
- FETCH:
  - imem_req=1, imem_addr=pc, pc_valid=0.
  - Hold until imem_ack=1, then go to ISSUE next cycle.
  - next_valid is ignored in FETCH.
  - Minimum fetch latency: 1 cycle from req to ack.
- ISSUE:
  - pc_valid=1, imem_req=0.
  - Wait for next_valid=1 (unbounded).
  - On next_valid, compute target T:
    - seq: pc+4.
    - branch: br_taken ? branch_adr : pc+4.
    - jal: jal_adr.
    - jalr: {jalr_adr[31:1],1'b0}.
    - trap: mtvec.
    - mret: mepc.
  - Arithmetic: pc+4 is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0), no flag.
  - Misalign check applies only to branch-taken, jal and jalr: T[1:0]!=0 is misaligned.
    - Misaligned: next cycle pc<=mtvec, bad_target<=T, misalign_trap=1 for exactly one cycle; go to REDIRECT.
    - Aligned: pc<=T, go to FETCH.
  - trap and mret targets are not checked; their low bits pass through unchanged.
- REDIRECT:
  - Single cycle; pc_valid=0, imem_req=0; then FETCH.
  - bad_target holds until the next misalign.
- pc changes only on the ISSUE→next-state edge (or reset).
- pc_valid is never high while imem_req is high.
- next_valid and imem_ack arriving in the same cycle while in FETCH: the ack is taken, next_valid is dropped.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- When defined, adds three outputs; all reset to 0, all wrap at 2^32:
  - instr_cnt (32): increments on each accepted next_valid.
  - redirect_cnt (32): increments when the selected source is not pc+4.
  - fetch_stall_cnt (32): increments each FETCH cycle with imem_ack=0.
- When undefined, the outputs and counters do not exist and the core behaviour is identical.

Test Plan:
- Reset then ack after 1 cycle, RESET_VEC=0 → imem_req=1 with imem_addr=0; next cycle pc_valid=1, pc=0; op=0 next_valid → pc=4, imem_addr=4.
- pc=0x100, op=1, br_taken=0, branch_adr=0x80 → pc=0x104. Repeat with br_taken=1 → pc=0x80.
- op=3, jalr_adr=0x2001 → pc=0x2000, no trap. jalr_adr=0x2002 → misalign_trap pulses 1 cycle, bad_target=0x2002, pc=mtvec=0x400, REDIRECT then FETCH at 0x400.
- pc=0xFFFF_FFFC, op=0 → pc=0x0000_0000. op=5 with mepc=0x3 → pc=0x3, no trap.
- imem_ack held low 5 cycles, next_valid pulsed during FETCH → imem_req stays high, pc unchanged, pc_valid=0; with PC_SEQ_PERF_EN, fetch_stall_cnt=5 and instr_cnt unchanged.
- RST asserted mid-FETCH and mid-REDIRECT → imem_req and pc_valid go to 0 immediately, pc=RESET_VEC; normal fetch resumes after release.
